// File: rtl/tnn_feature_loader.sv
// -----------------------------------------------------------------------------
// tnn_feature_loader
//
// Front end for the evolved tabular classifier cores. Quantised features arrive
// one per beat on a valid/ready stream; beat k of a frame is feature k and is
// written into the packed core input vector. Once a correctly framed frame has
// been assembled, the loader freezes core_x_o, waits CORE_LAT cycles for the
// external combinational core to settle, captures core_y_i and offers it on a
// valid/ready result channel. Short and long frames raise a one-cycle
// err_frame_o pulse and produce no result; the tail of a long frame is drained.
//
// Optional feature: define TNN_LOADER_STATS_EN to add result statistics
// counters (frame_cnt_o, pos_cnt_o).
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   s_valid_i    feature beat valid
//   s_ready_o    loader can accept a beat (registered)
//   s_data_i     feature value, FEAT_W bits
//   s_last_i     final beat of a frame
//   core_x_o     packed core input, feature k at [k*FEAT_W +: FEAT_W]
//   core_y_i     core decision (combinational function of core_x_o)
//   m_valid_o    result valid
//   m_ready_i    result consumer ready
//   m_class_o    captured decision
//   err_frame_o  one-cycle pulse per framing error
//   frame_cnt_o  (TNN_LOADER_STATS_EN) results handed over, wraps at 16 bits
//   pos_cnt_o    (TNN_LOADER_STATS_EN) results handed over with class 1
// -----------------------------------------------------------------------------
module tnn_feature_loader #(
  parameter int N_FEAT   = 5,
  parameter int FEAT_W   = 2,
  parameter int CORE_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [FEAT_W-1:0]          s_data_i,
  input  logic                       s_last_i,
  output logic [N_FEAT*FEAT_W-1:0]   core_x_o,
  input  logic                       core_y_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic                       m_class_o,
  output logic                       err_frame_o
`ifdef TNN_LOADER_STATS_EN
  ,
  output logic [15:0]                frame_cnt_o,
  output logic [15:0]                pos_cnt_o
`endif
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_OUTPUT  = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [LAT_W-1:0]           lat_q, lat_d;
  logic [N_FEAT*FEAT_W-1:0]   core_x_q, core_x_d;
  logic                       s_ready_q, s_ready_d;
  logic                       m_valid_q, m_valid_d;
  logic                       m_class_q, m_class_d;
  logic                       err_q, err_d;

  logic beat_acc_s;
  logic res_hs_s;

  assign beat_acc_s = s_valid_i & s_ready_q;
  assign res_hs_s   = m_valid_q & m_ready_i;

  // Next-state and next-output logic for the frame loader FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    core_x_d  = core_x_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    err_d     = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (beat_acc_s) begin
          for (int k = 0; k < N_FEAT; k++) begin
            if (idx_q == IDX_W'(k)) begin
              core_x_d[k*FEAT_W +: FEAT_W] = s_data_i;
            end else begin
              core_x_d[k*FEAT_W +: FEAT_W] = core_x_q[k*FEAT_W +: FEAT_W];
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d = {IDX_W{1'b0}};
            if (s_last_i) begin
              lat_d   = {LAT_W{1'b0}};
              state_d = S_EVAL;
            end else begin
              // Frame longer than N_FEAT: keep the first N_FEAT beats, drop the rest.
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s_last_i) begin
            // Short frame: discarded, stale features from earlier frames remain.
            err_d = 1'b1;
            idx_d = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      S_EVAL: begin
        if (lat_q == LAT_LAST) begin
          m_class_d = core_y_i;
          m_valid_d = 1'b1;
          state_d   = S_OUTPUT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        if (res_hs_s) begin
          m_valid_d = 1'b0;
          state_d   = S_COLLECT;
        end else begin
          m_valid_d = m_valid_q;
        end
      end

      S_DRAIN: begin
        if (beat_acc_s && s_last_i) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = S_COLLECT;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_COLLECT;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase

    // Registered ready: it follows the state being entered, so it is already
    // correct in the first cycle of COLLECT/DRAIN and low right after reset.
    s_ready_d = (state_d == S_COLLECT) || (state_d == S_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_COLLECT;
      idx_q     <= {IDX_W{1'b0}};
      lat_q     <= {LAT_W{1'b0}};
      core_x_q  <= {(N_FEAT*FEAT_W){1'b0}};
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_class_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      core_x_q  <= core_x_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      err_q     <= err_d;
    end
  end

  assign s_ready_o   = s_ready_q;
  assign core_x_o    = core_x_q;
  assign m_valid_o   = m_valid_q;
  assign m_class_o   = m_class_q;
  assign err_frame_o = err_q;

`ifdef TNN_LOADER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] pos_cnt_q, pos_cnt_d;

  // Result statistics; counters wrap naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pos_cnt_d   = pos_cnt_q;
    if (res_hs_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (m_class_q) begin
        pos_cnt_d = pos_cnt_q + 16'd1;
      end else begin
        pos_cnt_d = pos_cnt_q;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= 16'd0;
      pos_cnt_q   <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pos_cnt_q   <= pos_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign pos_cnt_o   = pos_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tnn_feature_loader.sv
// -----------------------------------------------------------------------------
// tb_tnn_feature_loader
//
// Self-checking bench for tnn_feature_loader. The classifier core is a
// stand-in combinational function (class 1 when the feature sum is <= 4),
// which agrees with the reference vectors 008->1, 084->1, 02B->0.
// A frame-level reference model tracks the stored features, the result
// channel and error pulses; a compare process checks every output on every
// falling edge, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tnn_feature_loader;

  localparam int NF = 5;
  localparam int FW = 2;
  localparam int CL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_data = 2'd0;
  logic        s_last = 1'b0;
  logic [9:0]  core_x;
  logic        core_y;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_class;
  logic        err_frame;
`ifdef TNN_LOADER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] pos_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit mr_rand = 1'b0;

  always #5 clk = ~clk;

  tnn_feature_loader #(.N_FEAT(NF), .FEAT_W(FW), .CORE_LAT(CL)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .core_x_o   (core_x),
    .core_y_i   (core_y),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_class_o  (m_class),
    .err_frame_o(err_frame)
`ifdef TNN_LOADER_STATS_EN
    ,
    .frame_cnt_o(frame_cnt),
    .pos_cnt_o  (pos_cnt)
`endif
  );

  // Stand-in classifier: class 1 when the sum of the five features is <= 4.
  function automatic logic core_fn(input logic [9:0] x);
    int s;
    s = 0;
    for (int k = 0; k < NF; k++) s += int'(x[2*k +: 2]);
    return (s <= 4);
  endfunction

  assign core_y = core_fn(core_x);

  // ---------------- reference model ----------------
  int         ph;        // 0 collecting, 1 settling, 2 holding result, 3 draining
  int         bidx;      // beats accepted so far in the current frame
  int         wcnt;
  logic [1:0] feats [NF];
  logic       e_rdy, e_mv, e_cls, e_err;
  logic [15:0] e_fc, e_pc;

  function automatic logic [9:0] pack_feats();
    logic [9:0] v;
    for (int k = 0; k < NF; k++) v[2*k +: 2] = feats[k];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; bidx <= 0; wcnt <= 0;
      for (int k = 0; k < NF; k++) feats[k] <= 2'd0;
      e_rdy <= 1'b0; e_mv <= 1'b0; e_cls <= 1'b0; e_err <= 1'b0;
      e_fc <= 16'd0; e_pc <= 16'd0;
    end else begin
      e_err <= 1'b0;
      case (ph)
        0: begin
          e_rdy <= 1'b1;
          if (s_valid && e_rdy) begin
            feats[bidx] <= s_data;
            if (bidx == NF - 1) begin
              bidx <= 0;
              if (s_last) begin ph <= 1; wcnt <= 0; e_rdy <= 1'b0; end
              else begin e_err <= 1'b1; ph <= 3; end
            end else if (s_last) begin
              e_err <= 1'b1; bidx <= 0;
            end else begin
              bidx <= bidx + 1;
            end
          end
        end
        1: begin
          if (wcnt + 1 >= CL) begin
            e_cls <= core_fn(pack_feats()); e_mv <= 1'b1; ph <= 2;
          end else begin
            wcnt <= wcnt + 1;
          end
        end
        2: begin
          if (m_ready) begin
            e_mv <= 1'b0; ph <= 0; e_rdy <= 1'b1;
            e_fc <= e_fc + 16'd1;
            if (e_cls) e_pc <= e_pc + 16'd1;
          end
        end
        3: begin
          if (s_valid && s_last) ph <= 0;
        end
        default: ph <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(e_rdy));
    chk("m_valid", 32'(m_valid), 32'(e_mv));
    chk("m_class", 32'(m_class), 32'(e_cls));
    chk("err_frame", 32'(err_frame), 32'(e_err));
    chk("core_x", 32'(core_x), 32'(pack_feats()));
`ifdef TNN_LOADER_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    chk("pos_cnt", 32'(pos_cnt), 32'(e_pc));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (mr_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [1:0] d, input logic l);
    int n;
    bit acc;
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      acc = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    s_data = 2'($urandom_range(0, 3));
    s_last = 1'($urandom_range(0, 1));
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [19:0] vals, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) tick();
      end
      send_beat(vals[2*k +: 2], (k == n - 1));
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_class", 32'(m_class), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    chk("rst_core_x", 32'(core_x), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("por_s_ready", 32'(s_ready), 32'd0);
    chk("por_core_x", 32'(core_x), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("first_ready", 32'(s_ready), 32'd1);

    // Basic frame 0,2,0,0,0 with consumer always ready.
    m_ready = 1'b1;
    send_frame(20'h00008, 5, 1'b0);
    chk("f1_core_x", 32'(core_x), 32'h008);
    chk("f1_mv_early", 32'(m_valid), 32'd0);
    tick();
    chk("f1_m_valid", 32'(m_valid), 32'd1);
    chk("f1_m_class", 32'(m_class), 32'd1);
    tick();
    chk("f1_mv_one_cycle", 32'(m_valid), 32'd0);
    chk("f1_ready_back", 32'(s_ready), 32'd1);

    send_frame(20'h00084, 5, 1'b0);
    tick();
    chk("f2_core_x", 32'(core_x), 32'h084);
    chk("f2_m_class", 32'(m_class), 32'd1);
    tick();
    send_frame(20'h0002B, 5, 1'b0);
    tick();
    chk("f3_core_x", 32'(core_x), 32'h02B);
    chk("f3_m_valid", 32'(m_valid), 32'd1);
    chk("f3_m_class", 32'(m_class), 32'd0);
    tick();

    // Backpressure on the result channel.
    m_ready = 1'b0;
    send_frame(20'h00008, 5, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_m_class", 32'(m_class), 32'd1);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("rel_m_valid", 32'(m_valid), 32'd0);
    chk("rel_s_ready", 32'(s_ready), 32'd1);

    // Short frame (last on beat 3).
    send_frame(20'h00039, 3, 1'b0);
    chk("short_err", 32'(err_frame), 32'd1);
    tick();
    chk("short_err_clear", 32'(err_frame), 32'd0);
    tick();
    chk("short_no_result", 32'(m_valid), 32'd0);
    send_frame(20'h00008, 5, 1'b0);
    tick();
    chk("after_short_class", 32'(m_class), 32'd1);
    chk("after_short_mv", 32'(m_valid), 32'd1);
    tick();

    // Long frame: 1,1,1,1,1,3,3 with last only on beat 7.
    send_frame(20'h03D55, 7, 1'b0);
    chk("long_core_x", 32'(core_x), 32'h155);
    chk("long_no_result", 32'(m_valid), 32'd0);
    send_frame(20'h00084, 5, 1'b0);
    tick();
    chk("after_long_class", 32'(m_class), 32'd1);
    chk("after_long_core_x", 32'(core_x), 32'h084);
    tick();

    // Reset while settling.
    m_ready = 1'b0;
    send_frame(20'h0002B, 5, 1'b0);
    pulse_reset();
    m_ready = 1'b1;
    send_frame(20'h00084, 5, 1'b0);
    tick();
    chk("post_rst1_mv", 32'(m_valid), 32'd1);
    chk("post_rst1_class", 32'(m_class), 32'd1);
    tick();

    // Reset while the result is held.
    m_ready = 1'b0;
    send_frame(20'h0002B, 5, 1'b0);
    tick();
    chk("out_mv_before_rst", 32'(m_valid), 32'd1);
    pulse_reset();
    m_ready = 1'b1;
    send_frame(20'h00008, 5, 1'b0);
    tick();
    chk("post_rst2_class", 32'(m_class), 32'd1);
    tick();
    send_frame(20'h00084, 5, 1'b0);
    tick();
    tick();
    send_frame(20'h0002B, 5, 1'b0);
    tick();
    chk("third_class", 32'(m_class), 32'd0);
    tick();
`ifdef TNN_LOADER_STATS_EN
    chk("stats_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("stats_pos_cnt", 32'(pos_cnt), 32'd2);
`endif

    // Randomized frames: mostly well formed, some short or long, random gaps
    // and random result backpressure.
    mr_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int r;
      int n;
      r = $urandom_range(0, 9);
      if (r < 6) n = 5;
      else if (r < 8) n = $urandom_range(1, 4);
      else n = $urandom_range(6, 9);
      send_frame(20'($urandom), n, 1'b1);
    end
    mr_rand = 1'b0;
    m_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
